dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/dmem_arbiter_rr_arb2.sv | 10 +
 rtl/dmem_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, port ids and latency limits for the data-memory arbiter
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_DBG    = 1'b1;
  localparam int   MEM_LAT_MAX = 4;
  localparam int   CNT_W       = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; a lone request wins, a tie goes to the port not granted last
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  always_comb grant = (req == 2'b11) ? ~last : (req[PORT_DBG] ? PORT_DBG : PORT_CPU);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data memory between the CPU and a debug/loader port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             owner, we, last, grant, any_req, access, resp_rd;
  logic [31:0]      addr, wdata, cpu_q, dbg_q;

  rr_arb2 u_arb (.req({dbg_req, cpu_req}), .last(last), .grant(grant));

  assign any_req = cpu_req | dbg_req;
  assign access  = state == ACCESS;
  assign resp_rd = state == RESP && !we;

  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
               (state == ACCESS) ? ((cnt == CNT_W'(1)) ? RESP : ACCESS) : IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= PORT_CPU;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      last  <= PORT_DBG;
      cpu_q <= '0;
      dbg_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner <= grant;
        last  <= grant;
        we    <= (grant == PORT_DBG) ? dbg_we    : cpu_we;
        addr  <= (grant == PORT_DBG) ? dbg_addr  : cpu_addr;
        wdata <= (grant == PORT_DBG) ? dbg_wdata : cpu_wdata;
        cnt   <= CNT_W'(MEM_LAT);
      end
      if (access) cnt <= cnt - 1'b1;
      if (resp_rd && owner == PORT_CPU) cpu_q <= mem_rdata;
      if (resp_rd && owner == PORT_DBG) dbg_q <= mem_rdata;
    end
  end

  // read data is forwarded straight from memory in the done cycle, then held in the port register
  assign mem_addr  = access ? addr  : '0;
  assign mem_wdata = access ? wdata : '0;
  assign mem_write = access && we;
  assign mem_read  = access && !we;
  assign cpu_done  = state == RESP && owner == PORT_CPU;
  assign dbg_done  = state == RESP && owner == PORT_DBG;
  assign cpu_rdata = (resp_rd && owner == PORT_CPU) ? mem_rdata : cpu_q;
  assign dbg_rdata = (resp_rd && owner == PORT_DBG) ? mem_rdata : dbg_q;
  assign cpu_stall = cpu_req && !cpu_done;
endmodule
